// File: rtl/fetch_queue.sv
// Decoupled fetch->decode FIFO of {pc, instr} pairs with synchronous flush.
// Optional zero-latency bypass when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ILEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [ILEN-1:0]          in_instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [ILEN-1:0]          out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] CountFull = CW'(DEPTH);
  localparam logic [CW-1:0] CountOne  = CW'(1);
  localparam logic [PW-1:0] PtrOne    = PW'(1);

  logic [XLEN+ILEN-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic empty;
  logic bypass;
  logic push;
  logic pop;

  assign empty    = (count_q == '0);
  assign in_ready = (count_q != CountFull);
  assign count    = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty & in_valid & ~flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry taken by the decoder this cycle never touches storage.
  assign pop  = ~empty & out_ready & ~flush;
  assign push = in_valid & in_ready & ~flush & ~(bypass & out_ready);

  always_comb begin
    out_valid = ~empty | bypass;
    out_pc    = '0;
    out_instr = '0;
    if (bypass) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end else if (!empty) begin
      {out_pc, out_instr} = mem[rd_ptr_q];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      if (push && !pop) begin
        count_d = count_q + CountOne;
      end else if (pop && !push) begin
        count_d = count_q - CountOne;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {in_pc, in_instr};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed plan steps plus random traffic
// compared against a queue-based reference model.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XL    = 32;
  localparam int unsigned IL    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [XL-1:0] in_pc;
  logic [IL-1:0] in_instr;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [XL-1:0] out_pc;
  logic [IL-1:0] out_instr;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int passes = 0;

  logic [XL+IL-1:0] model_q [$];

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XL), .ILEN(IL)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [IL-1:0] instr_of(input logic [XL-1:0] pc);
    return pc ^ 32'hC0DE_0013;
  endfunction

  task automatic drive(input logic v, input logic [XL-1:0] pc, input logic f, input logic r);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr_of(pc);
    flush     = f;
    out_ready = r;
  endtask

  // Check outputs against the model, then advance one clock and update the model.
  task automatic step(input string tag);
    logic        exp_v;
    logic [XL-1:0] exp_pc;
    logic [IL-1:0] exp_in;
    logic        bypass;
    int          n;
    #1;
    n      = model_q.size();
    bypass = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass = (n == 0) && in_valid && !flush;
`endif
    exp_v  = (n != 0) || bypass;
    exp_pc = '0;
    exp_in = '0;
    if (bypass) begin
      exp_pc = in_pc;
      exp_in = in_instr;
    end else if (n != 0) begin
      {exp_pc, exp_in} = model_q[0];
    end
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(exp_v));
    chk({tag, ".out_pc"},    64'(out_pc),    64'(exp_pc));
    chk({tag, ".out_instr"}, 64'(out_instr), 64'(exp_in));
    chk({tag, ".count"},     64'(count),     64'(n));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(n != DEPTH));
    @(posedge clk);
    if (flush) begin
      model_q.delete();
    end else if (bypass && out_ready) begin
      // consumed straight through, nothing stored
    end else begin
      if (n != 0 && out_ready) void'(model_q.pop_front());
      if (in_valid && n != DEPTH) model_q.push_back({in_pc, in_instr});
    end
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    #12;
    chk("reset.count", 64'(count), 64'd0);
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Fill to FULL with decoder stalled, then offer a fifth entry.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'(4 * k), 1'b0, 1'b0);
      step("fill");
    end
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    step("fifth");
    chk("full.count", 64'(count), 64'd4);
    chk("full.head", 64'(out_pc), 64'h0);

    // Drain from FULL.
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, 1'b0, 1'b1);
      step("drain");
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    step("drained");

    // Continuous push/pop of 10 entries across the wrap point.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h100 + 32'(4 * k), 1'b0, 1'b1);
      step("wrap");
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    step("wrap_tail");

    // Flush with count=3 while pushing 0x40 and popping.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h200 + 32'(4 * k), 1'b0, 1'b0);
      step("pre_flush");
    end
    drive(1'b1, 32'h40, 1'b1, 1'b1);
    step("flush");
    chk("post_flush.count", 64'(count), 64'd0);
    chk("post_flush.out_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 32'h80, 1'b0, 1'b0);
    step("push_80");
    drive(1'b0, '0, 1'b0, 1'b1);
    step("see_80");
    drive(1'b0, '0, 1'b0, 1'b1);
    step("idle");

    // Empty queue, offer 0x20 with decoder ready.
    drive(1'b1, 32'h20, 1'b0, 1'b1);
    step("bypass_offer");
    drive(1'b0, '0, 1'b0, 1'b1);
    step("bypass_next");
    drive(1'b0, '0, 1'b0, 1'b1);
    step("bypass_idle");

    // Async reset mid-stream with count=3, checked before any clock edge.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h300 + 32'(4 * k), 1'b0, 1'b0);
      step("pre_reset");
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    model_q.delete();
    chk("async_reset.count", 64'(count), 64'd0);
    chk("async_reset.out_valid", 64'(out_valid), 64'd0);
    chk("async_reset.out_pc", 64'(out_pc), 64'd0);
    chk("async_reset.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 3) != 0), 32'($urandom) & 32'hFFFF_FFFC,
            1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) != 0));
      step("rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction fetch queue between the fetch stage and the decoder.
- Replaces the direct fetch→decode coupling (single instruction register plus stall/nop) with a DEPTH-entry decoupled valid/ready FIFO of {pc, instruction} pairs.
- Supports a synchronous flush on a taken jump/branch, so fetch can run ahead of a stalled decoder without losing or duplicating instructions.

Parameters:
- DEPTH, 4, number of queue entries; power of two, ≥2.
- XLEN, 32, PC width in bits.
- ILEN, 32, instruction width in bits.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  fetch presents a valid {in_pc, in_instr}.
- in_ready  output  1  queue can accept an entry this cycle.
- in_pc  input  XLEN  PC of the offered instruction.
- in_instr  input  ILEN  offered instruction word.
- flush  input  1  jump/branch taken in EX; discard all queued and incoming entries.
- out_valid  output  1  head entry valid for the decoder.
- out_ready  input  1  decoder consumes the head this cycle (i.e. the decoder is not stalled).
- out_pc  output  XLEN  PC of the head entry.
- out_instr  output  ILEN  instruction word of the head entry.
- count  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Storage: circular buffer, DEPTH × (XLEN+ILEN).
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
  - count ranges 0..DEPTH.
- Reset (reset=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, out_valid=0, out_pc=0, out_instr=0.
  - Storage array is not reset.
  - in_ready=1 as soon as reset deasserts.
  - A reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.
- Occupancy state, derived from count:
  - EMPTY: count=0.
  - PARTIAL: 0<count<DEPTH.
  - FULL: count=DEPTH.
- in_ready = (count != DEPTH). It is combinational from state only and never depends on out_ready.
- push = in_valid & in_ready & ~flush.
  - On push: mem[wr_ptr] ← {in_pc, in_instr}; wr_ptr ← wr_ptr+1.
- pop = out_valid & out_ready & ~flush.
  - On pop: rd_ptr ← rd_ptr+1.
- count update: count ← count + push − pop.
  - Simultaneous push and pop in PARTIAL leaves count unchanged.
  - In FULL, push is impossible (in_ready=0) even if pop occurs; in_ready rises the cycle after the pop.
- out_valid = (count != 0).
  - out_pc and out_instr = mem[rd_ptr] when out_valid=1, else 0. Outputs are masked and must not show stale data.
- Latency: an entry pushed at edge N is visible at the outputs after edge N (one cycle). There is no bypass when EMPTY, unless the optional feature is enabled.
- Output hold: while out_valid=1 and out_ready=0, out_pc and out_instr remain stable.
- Flush (synchronous, highest priority):
  - At the edge: wr_ptr ← 0, rd_ptr ← 0, count ← 0.
  - Any push or pop in the flush cycle is discarded and not counted.
  - out_valid=0 in the cycle after the flush.
  - in_ready stays as computed from the pre-flush count during the flush cycle.
  - A push in the cycle after the flush is accepted normally.
- Wrap-around: continuous push/pop across more than DEPTH entries preserves FIFO order with no bubble, sustaining 1 entry/cycle in steady state.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count=0, in_valid=1 and flush=0: out_valid=1, and out_pc/out_instr are driven combinationally from in_pc/in_instr.
  - If out_ready=1 in that cycle, the entry is consumed directly: no write, pointers and count unchanged.
  - If out_ready=0, the entry is pushed normally.
  - Latency becomes zero when EMPTY.
- Not defined: out_valid depends only on count, with one-cycle latency as above.

Test Plan:
- Reset: assert reset=0 mid-stream with count=3 → count=0, out_valid=0, out_pc=0 and in_ready=1 immediately, before any clock edge.
- Fill: DEPTH=4, out_ready=0, push pc 0x00,0x04,0x08,0x0C → count=4 and in_ready=0; a fifth push (pc 0x10) is not accepted; out_pc holds 0x00.
- Drain/order: from FULL, out_ready=1 for 4 cycles → out_pc sequence 0x00,0x04,0x08,0x0C; then out_valid=0 and count=0.
- Wrap-around: continuous push and pop of 10 entries, pc 0x100+4k → outputs in order with count steady at 1 and no lost or duplicated pc.
- Flush: count=3, flush=1 together with in_valid=1 (pc 0x40) and out_ready=1 → next cycle count=0 and out_valid=0; 0x40 never appears at the output; next push of pc 0x80 appears one cycle later.
- Bypass (FETCH_QUEUE_BYPASS_EN): EMPTY, in_valid=1 with pc 0x20, out_ready=1 → out_valid=1 and out_pc=0x20 in the same cycle, count stays 0. Without the macro, the same stimulus gives out_valid=0 that cycle and out_pc=0x20 the next.
